// File: rtl/hex_str_render_if.sv
// Handshake bundle between the hex string renderer, its requester, the glyph
// ROM stage and the framebuffer writer.
interface hex_str_render_if #(
  parameter int DIGIT_N  = 8,
  parameter int CH_W     = 4,
  parameter int CH_ROW_W = 3,
  parameter int X_W      = ($clog2(DIGIT_N*8) < 1) ? 1 : $clog2(DIGIT_N*8)
);
  logic                  start;
  logic [DIGIT_N*4-1:0]  value;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic [CH_W-1:0]       ch_sel;
  logic [CH_ROW_W-1:0]   row_sel;
  logic                  ch_px_rd;
  logic                  ch_px_valid;
  logic                  ch_px_in;
  logic                  px_valid;
  logic                  px_data;
  logic [X_W-1:0]        px_x;
  logic [CH_ROW_W-1:0]   px_y;
  logic                  px_last;

  modport slave (
    input  start, value, blank_lz, ch_px_valid, ch_px_in,
    output busy, done, ch_sel, row_sel, ch_px_rd,
           px_valid, px_data, px_x, px_y, px_last
  );

  modport master (
    output start, value, blank_lz, ch_px_valid, ch_px_in,
    input  busy, done, ch_sel, row_sel, ch_px_rd,
           px_valid, px_data, px_x, px_y, px_last
  );
endinterface

// File: rtl/hex_str_render.sv
// Sequences glyph-row reads for a DIGIT_N-digit hex string and turns the
// returned serial glyph pixels into a raster-ordered (x, y, data) stream.
module hex_str_render #(
  parameter int DIGIT_N  = 8,
  parameter int CH_W     = 4,
  parameter int CH_ROW_W = 3,
  parameter int CH_COL_W = 3,
  parameter int X_W      = ($clog2(DIGIT_N*8) < 1) ? 1 : $clog2(DIGIT_N*8)
) (
  input  logic              clk,
  input  logic              rst_n,
  hex_str_render_if.slave   bus
);
  localparam int DIG_W = (DIGIT_N > 1) ? $clog2(DIGIT_N) : 1;
  localparam int VAL_W = DIGIT_N * 4;
  localparam logic [DIG_W-1:0]    DIG_LAST = DIG_W'(DIGIT_N - 1);
  localparam logic [CH_COL_W-1:0] COL_LAST = '1;
  localparam logic [CH_ROW_W-1:0] ROW_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state, w_state_next;
  logic [VAL_W-1:0]    r_value;
  logic [DIGIT_N-1:0]  r_mask, w_mask;
  logic [CH_COL_W-1:0] r_col, w_col_next;
  logic [DIG_W-1:0]    r_dig, w_dig_next;
  logic [CH_ROW_W-1:0] r_row, w_row_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_rd, w_rd_next;
  logic [CH_W-1:0]     r_ch_sel, w_ch_sel_next;
  logic [CH_ROW_W-1:0] r_row_sel, w_row_sel_next;
  logic                w_latch;
  logic                w_issue_last;
  logic [3:0]          w_sel_nib;

  logic [CH_COL_W-1:0] r_rcol;
  logic [DIG_W-1:0]    r_rdig;
  logic [CH_ROW_W-1:0] r_rrow;
  logic                r_px_valid, r_px_data, r_px_last;
  logic [X_W-1:0]      r_px_x;
  logic [CH_ROW_W-1:0] r_px_y;
  logic                w_rx_mask;
  logic                w_rx_last;

  logic [3:0] w_nib    [DIGIT_N];
  logic [3:0] w_in_nib [DIGIT_N];

  // Digit 0 is the most significant nibble.
  for (genvar gi = 0; gi < DIGIT_N; gi++) begin : g_nib
    assign w_nib[gi]    = r_value[(DIGIT_N-1-gi)*4 +: 4];
    assign w_in_nib[gi] = bus.value[(DIGIT_N-1-gi)*4 +: 4];
  end

  // A digit blanks only while every more-significant digit is also zero.
  always_comb begin
    logic w_all_zero;
    w_all_zero = 1'b1;
    w_mask     = '0;
    for (int d = 0; d < DIGIT_N; d++) begin
      w_all_zero = w_all_zero & (w_in_nib[d] == 4'd0);
      w_mask[d]  = bus.blank_lz & w_all_zero & (d != DIGIT_N - 1);
    end
  end

  assign w_issue_last = (r_col == COL_LAST) && (r_dig == DIG_LAST) && (r_row == ROW_LAST);

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_dig_next   = r_dig;
    w_row_next   = r_row;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_rd_next    = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
          w_latch      = 1'b1;
          w_col_next   = '0;
          w_dig_next   = '0;
          w_row_next   = '0;
          w_rd_next    = 1'b1;
          w_busy_next  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_issue_last) begin
          w_state_next = S_DRAIN;
        end else begin
          w_rd_next  = 1'b1;
          w_col_next = r_col + 1'b1;
          if (r_col == COL_LAST) begin
            w_dig_next = (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
            if (r_dig == DIG_LAST) w_row_next = r_row + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_px_last) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nib = '0;
    for (int d = 0; d < DIGIT_N; d++) begin
      if (w_dig_next == DIG_W'(d)) w_sel_nib = w_latch ? w_in_nib[d] : w_nib[d];
    end
    w_ch_sel_next  = w_rd_next ? CH_W'(w_sel_nib) : '0;
    w_row_sel_next = w_rd_next ? w_row_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_value   <= '0;
      r_mask    <= '0;
      r_col     <= '0;
      r_dig     <= '0;
      r_row     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= 1'b0;
      r_ch_sel  <= '0;
      r_row_sel <= '0;
    end else begin
      r_state   <= w_state_next;
      r_col     <= w_col_next;
      r_dig     <= w_dig_next;
      r_row     <= w_row_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_rd      <= w_rd_next;
      r_ch_sel  <= w_ch_sel_next;
      r_row_sel <= w_row_sel_next;
      if (w_latch) begin
        r_value <= bus.value;
        r_mask  <= w_mask;
      end
    end
  end

  always_comb begin
    w_rx_mask = 1'b0;
    for (int d = 0; d < DIGIT_N; d++) begin
      if (r_rdig == DIG_W'(d)) w_rx_mask = r_mask[d];
    end
  end

  assign w_rx_last = (r_rcol == COL_LAST) && (r_rdig == DIG_LAST) && (r_rrow == ROW_LAST);

  // Receive side runs on its own counters; glyph pixels arrive leftmost first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcol     <= '0;
      r_rdig     <= '0;
      r_rrow     <= '0;
      r_px_valid <= 1'b0;
      r_px_data  <= 1'b0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_px_last  <= 1'b0;
    end else begin
      r_px_valid <= 1'b0;
      r_px_data  <= 1'b0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_px_last  <= 1'b0;
      if (w_latch) begin
        r_rcol <= '0;
        r_rdig <= '0;
        r_rrow <= '0;
      end else if (r_state != S_IDLE && bus.ch_px_valid) begin
        r_px_valid <= 1'b1;
        r_px_data  <= bus.ch_px_in & ~w_rx_mask;
        r_px_x     <= X_W'({r_rdig, r_rcol});
        r_px_y     <= r_rrow;
        r_px_last  <= w_rx_last;
        r_rcol     <= r_rcol + 1'b1;
        if (r_rcol == COL_LAST) begin
          r_rdig <= (r_rdig == DIG_LAST) ? '0 : r_rdig + 1'b1;
          if (r_rdig == DIG_LAST) r_rrow <= r_rrow + 1'b1;
        end
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ch_px_rd = r_rd;
  assign bus.ch_sel   = r_ch_sel;
  assign bus.row_sel  = r_row_sel;
  assign bus.px_valid = r_px_valid;
  assign bus.px_data  = r_px_data;
  assign bus.px_x     = r_px_x;
  assign bus.px_y     = r_px_y;
  assign bus.px_last  = r_px_last;

  // Once the final pixel has been taken the glyph stage must stay quiet.
  a_no_valid_after_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_DRAIN && r_px_last) |-> !bus.ch_px_valid);
endmodule

// File: tb/tb_hex_str_render.sv
// Directed bench: an 8-digit and a 1-digit renderer fed by a golden glyph
// stage, checked every cycle against a raster-level reference model.
module tb_hex_str_render;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_str_render_if #(.DIGIT_N(8)) if8 ();
  hex_str_render_if #(.DIGIT_N(1)) if1 ();

  hex_str_render #(.DIGIT_N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  hex_str_render #(.DIGIT_N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Glyph rows, row 0 in the top byte; bit 0 of each byte is the leftmost pixel.
  logic [63:0] font_rows [16] = '{
    64'h3C66766E66663C00, 64'h181C181818187E00, 64'h3C6660300C067E00, 64'h3C66603860663C00,
    64'h303834327E303000, 64'h7E063E6060663C00, 64'h3C063E6666663C00, 64'h7E6030180C0C0C00,
    64'h3C66663C66663C00, 64'h3C66667C60663C00, 64'h183C66667E666600, 64'h3E66663E66663E00,
    64'h3C66060606663C00, 64'h1E36666666361E00, 64'h7E06063E06067E00, 64'h7E06063E06060600};

  function automatic logic [7:0] font_byte(input int g, input int r);
    logic [63:0] w;
    w = font_rows[g];
    return w[(7-r)*8 +: 8];
  endfunction

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Glyph stage: two-cycle pipeline, column counted from the start of each glyph.
  logic [10:0] g8_s1 = '0, g8_s2 = '0, g1_s1 = '0, g1_s2 = '0;
  logic [2:0]  g8_col = '0, g1_col = '0;
  always @(posedge clk) begin
    g8_col <= if8.ch_px_rd ? g8_col + 3'd1 : 3'd0;
    g8_s1  <= {if8.ch_px_rd, if8.ch_sel, if8.row_sel, g8_col};
    g8_s2  <= g8_s1;
    g1_col <= if1.ch_px_rd ? g1_col + 3'd1 : 3'd0;
    g1_s1  <= {if1.ch_px_rd, if1.ch_sel, if1.row_sel, g1_col};
    g1_s2  <= g1_s1;
  end
  logic [7:0] g8_byte, g1_byte;
  assign g8_byte = font_byte(int'(g8_s2[9:6]), int'(g8_s2[5:3]));
  assign g1_byte = font_byte(int'(g1_s2[9:6]), int'(g1_s2[5:3]));
  assign if8.ch_px_valid = g8_s2[10];
  assign if8.ch_px_in    = g8_s2[10] & g8_byte[g8_s2[2:0]];
  assign if1.ch_px_valid = g1_s2[10];
  assign if1.ch_px_in    = g1_s2[10] & g1_byte[g1_s2[2:0]];

  task automatic chk(input int id, input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL u%0d.%s cyc=%0d got=%0h want=%0h", id, nm, cyc, got, exp);
    end
  endtask

  // Reference model: one render = start edge E0, then fixed phase offsets.
  bit          m_act [2] = '{0, 0};
  longint      m_e0  [2] = '{0, 0};
  logic [63:0] m_v   [2];
  bit          m_b   [2];
  logic [7:0]  cap   [2][16][8];

  task automatic model_step(input int id, input int n, input logic busy, input logic done,
                            input logic rd, input logic [3:0] sel, input logic [2:0] rsel,
                            input logic vld, input logic dat, input logic [6:0] x,
                            input logic [2:0] y, input logic last, input logic st,
                            input logic [63:0] val, input logic bl);
    longint p;
    int k, px, py, dg, cl;
    logic [63:0] sh;
    logic [7:0] fb;
    bit busy_e, rd_e, vld_e, done_e, blank;
    if (!rst_n) m_act[id] = 0;
    p = cyc - m_e0[id];
    busy_e = m_act[id] && p >= 0 && p <= 64*n + 2;
    rd_e   = m_act[id] && p >= 0 && p <= 64*n - 1;
    vld_e  = m_act[id] && p >= 3 && p <= 64*n + 2;
    done_e = m_act[id] && p == 64*n + 3;
    chk(id, "busy", busy, busy_e);
    chk(id, "ch_px_rd", rd, rd_e);
    chk(id, "px_valid", vld, vld_e);
    chk(id, "done", done, done_e);
    if (rd_e) begin
      dg = int'((p / 8) % n);
      sh = m_v[id] >> ((n - 1 - dg) * 4);
      chk(id, "ch_sel", sel, sh[3:0]);
      chk(id, "row_sel", rsel, p / (8*n));
    end
    if (vld_e) begin
      k  = int'(p - 3);
      py = k / (8*n);
      px = k % (8*n);
      dg = px / 8;
      cl = px % 8;
      sh = m_v[id] >> ((n - 1 - dg) * 4);
      blank = m_b[id] && (sh == 0) && (dg != n - 1);
      fb = font_byte(int'(sh[3:0]), py);
      chk(id, "px_x", x, px);
      chk(id, "px_y", y, py);
      chk(id, "px_data", dat, blank ? 1'b0 : fb[cl]);
      chk(id, "px_last", last, k == 64*n - 1);
      cap[id][dg][py][cl] = dat;
    end
    if (m_act[id] && p >= 64*n + 3) m_act[id] = 0;
    if (rst_n && st && !busy_e) begin
      m_act[id] = 1;
      m_e0[id]  = cyc + 1;
      m_v[id]   = val;
      m_b[id]   = bl;
      for (int d = 0; d < 16; d++)
        for (int r = 0; r < 8; r++) cap[id][d][r] = '0;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 8, if8.busy, if8.done, if8.ch_px_rd, if8.ch_sel, if8.row_sel, if8.px_valid,
               if8.px_data, 7'(if8.px_x), if8.px_y, if8.px_last, if8.start, 64'(if8.value), if8.blank_lz);
    model_step(1, 1, if1.busy, if1.done, if1.ch_px_rd, if1.ch_sel, if1.row_sel, if1.px_valid,
               if1.px_data, 7'(if1.px_x), if1.px_y, if1.px_last, if1.start, 64'(if1.value), if1.blank_lz);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [31:0] v, input logic b);
    if8.start = 1'b1; if8.value = v; if8.blank_lz = b;
    tick();
    if8.start = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int t;
    logic d;
    t = 0;
    d = (id == 0) ? if8.done : if1.done;
    while (!d && t < 2000) begin
      tick();
      t++;
      d = (id == 0) ? if8.done : if1.done;
    end
    chk(id, "done_seen", d, 1'b1);
  endtask

  initial begin
    logic [7:0] acc;
    if8.start = 1'b0; if8.value = '0; if8.blank_lz = 1'b0;
    if1.start = 1'b0; if1.value = '0; if1.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(0, "rst_busy", if8.busy, 0);        chk(0, "rst_done", if8.done, 0);
    chk(0, "rst_rd", if8.ch_px_rd, 0);      chk(0, "rst_ch_sel", if8.ch_sel, 0);
    chk(0, "rst_row_sel", if8.row_sel, 0);  chk(0, "rst_px_valid", if8.px_valid, 0);
    chk(0, "rst_px_data", if8.px_data, 0);  chk(0, "rst_px_x", if8.px_x, 0);
    chk(0, "rst_px_y", if8.px_y, 0);        chk(0, "rst_px_last", if8.px_last, 0);
    rst_n = 1'b1;
    tick();

    // Plain render, with a start pulse at E100 that must be ignored.
    start8(32'h0123ABCD, 1'b0);
    repeat (99) tick();
    start8(32'hFFFFFFFF, 1'b1);
    wait_done(0);
    chk(0, "litA_d0r0", cap[0][0][0], 8'h3C);
    chk(0, "litA_d1r0", cap[0][1][0], 8'h18);
    chk(0, "litA_d4r2", cap[0][4][2], 8'h66);
    chk(0, "litA_d7r6", cap[0][7][6], 8'h1E);

    // Leading-zero blanking, started in the done cycle.
    start8(32'h00000001, 1'b1);
    wait_done(0);
    acc = '0;
    for (int d = 0; d < 7; d++) for (int r = 0; r < 8; r++) acc |= cap[0][d][r];
    chk(0, "litB_blank", acc, 8'h00);
    chk(0, "litB_d7r0", cap[0][7][0], 8'h18);
    chk(0, "litB_d7r6", cap[0][7][6], 8'h7E);

    // All-zero value, blanked then unblanked.
    start8(32'h0, 1'b1);
    wait_done(0);
    acc = '0;
    for (int d = 0; d < 7; d++) for (int r = 0; r < 8; r++) acc |= cap[0][d][r];
    chk(0, "litC_blank", acc, 8'h00);
    chk(0, "litC_d7r2", cap[0][7][2], 8'h76);
    start8(32'h0, 1'b0);
    wait_done(0);
    for (int d = 0; d < 8; d++) chk(0, "litD_row3", cap[0][d][3], 8'h6E);

    // Reset mid-render at E200, held two cycles.
    start8(32'h0123ABCD, 1'b0);
    repeat (199) tick();
    rst_n = 1'b0;
    #1;
    chk(0, "abort_busy", if8.busy, 0);
    chk(0, "abort_rd", if8.ch_px_rd, 0);
    chk(0, "abort_px_valid", if8.px_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start8(32'h89ABCDEF, 1'b1);
    wait_done(0);
    chk(0, "litF_d0r0", cap[0][0][0], 8'h3C);
    chk(0, "litF_d7r0", cap[0][7][0], 8'h7E);

    // Single-digit instance: 0xF is never blanked.
    if1.start = 1'b1; if1.value = 4'hF; if1.blank_lz = 1'b1;
    tick();
    if1.start = 1'b0;
    wait_done(1);
    chk(1, "litG_r0", cap[1][0][0], 8'h7E);
    chk(1, "litG_r3", cap[1][0][3], 8'h3E);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hex_str_render.md
Name: hex_str_render

Overview:
- Upstream sequencer for the hex character pixel ROM stage (8x8 glyphs, one ROM byte per glyph row, bit0 = leftmost pixel).
- On start, latches a DIGIT_N-nibble value and walks glyph rows 0..7. For each row it walks digits MS→LS, holding ch_px_rd for 8 cycles per glyph.
- Consumes the serial pixel stream returned by the glyph stage and emits a raster-ordered pixel stream (x, y, data) for the display framebuffer writer.
- Optional leading-zero blanking.

Parameters:
- DIGIT_N, 8: number of hex digits rendered; legal range 1..16.
- CH_W, 4: glyph select width.
- CH_ROW_W, 3: glyph row select width (8 rows).
- CH_COL_W, 3: glyph column counter width (8 px).
- X_W, $clog2(DIGIT_N*8) (min 1): px_x width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  render request; sampled only when busy=0.
- value  in  DIGIT_N*4  number to render; latched on accepted start.
- blank_lz  in  1  leading-zero blanking enable; latched on accepted start.
- busy  out  1  render in progress.
- done  out  1  one-cycle pulse after the last pixel is emitted.
- ch_sel  out  CH_W  glyph select to the glyph stage.
- row_sel  out  CH_ROW_W  glyph row select to the glyph stage.
- ch_px_rd  out  1  pixel read request to the glyph stage.
- ch_px_valid  in  1  glyph stage pixel valid.
- ch_px_in  in  1  glyph stage pixel value.
- px_valid  out  1  output pixel valid.
- px_data  out  1  output pixel value (blanking applied).
- px_x  out  X_W  pixel column, 0..DIGIT_N*8-1.
- px_y  out  CH_ROW_W  pixel row, 0..7.
- px_last  out  1  marks the pixel at x=DIGIT_N*8-1, y=7.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters and latches cleared. Reset mid-render aborts immediately; no done is generated.
- FSM states: IDLE → RUN → DRAIN → IDLE.
- IDLE:
  - start=1 at edge E0 latches value and blank_lz, and computes blank mask.
  - Mask bit d (d=0 is the MS digit) = blank_lz AND nibbles 0..d all zero AND d≠DIGIT_N-1. The LS digit is never blanked.
  - Go to RUN; busy=1 after E0.
- RUN:
  - ch_px_rd=1 for exactly 64*DIGIT_N consecutive cycles, from after E0 through after E(64*DIGIT_N-1).
  - Issue counters: col (0..7), digit (0..DIGIT_N-1), row (0..7). col increments every cycle. When col wraps, digit increments. When digit wraps, row increments.
  - ch_sel = nibble of the current digit, with digit 0 = value[DIGIT_N*4-1 -: 4]. row_sel = row. Both are registered and stable for each 8-cycle group.
  - No gaps between glyphs or rows.
  - After the final issue cycle, ch_px_rd=0 and go to DRAIN.
- Glyph stage contract: ch_px_valid follows ch_px_rd by 2 cycles and stays continuous. Pixels arrive LSB first. The first valid follows E2.
- Receive side:
  - Independent rx counters (rcol, rdig, rrow) advance only on ch_px_valid.
  - Output is registered, 1 cycle after ch_px_valid: px_valid=ch_px_valid; px_data=ch_px_in & ~mask[rdig]; px_x=rdig*8+rcol; px_y=rrow.
  - Total latency: first px_valid after E3; last after E(64*DIGIT_N+2).
- DRAIN:
  - On the cycle px_last is emitted, the next edge pulses done=1 for one cycle, drops busy to 0, and returns to IDLE.
  - start is accepted again in the done cycle (busy=0 there).
- start while busy=1: ignored. Latched value and blank_lz are unaffected; no extra render occurs.
- ch_px_valid outside RUN/DRAIN: ignored; no px_valid is produced.
- px_valid is never deasserted mid-render: exactly 64*DIGIT_N contiguous px_valid cycles.
- Assertion: in DRAIN, ch_px_valid must not reassert after the rx counters have wrapped.

Test Plan:
- Timing, no blanking: DIGIT_N=8, value=0x0123ABCD, blank_lz=0, glyph stage with golden font model.
  - Required: ch_px_rd high for 512 cycles after E0.
  - Required: px_valid E3..E514 contiguous; px_x 0..63 repeated per px_y 0..7; px_last once; done after E515.
  - Required: every pixel matches font[nibble][row] bit col.
- Leading-zero blanking: value=0x00000001, blank_lz=1.
  - Required: px_data=0 for all x<56.
  - Required: x 56..63 match the glyph '1'.
- All-zero value: value=0, blank_lz=1.
  - Required: only x 56..63 are non-blank (glyph '0').
  - Required: with blank_lz=0, all eight digits show '0'.
- start while busy: start pulsed at E100 with value=0xFFFFFFFF during the run above.
  - Required: output unchanged (0x0123ABCD); single done.
  - Required: start at the done cycle begins a new render with first px_valid 3 cycles later.
- Reset mid-render: rst_n low at E200 for 2 cycles.
  - Required: all outputs 0 immediately; no done.
  - Required: a fresh start after release renders correctly from x=0, y=0.
- Minimum size: DIGIT_N=1, value=0xF.
  - Required: 64 rd cycles; px_x 0..7; done after E67; blank mask 0 even with blank_lz=1.
